// File: rtl/noc_vc_tx_arbiter_pkg.sv
// Shared constants and sizing helpers for the VC transmit arbiter.
package noc_vc_tx_arbiter_pkg;
  localparam int DEFAULT_VC_W        = 2;
  localparam int DEFAULT_A_W         = 8;
  localparam int DEFAULT_D_W         = 16;
  localparam int DEFAULT_MAX_CREDITS = 4;

  function automatic int cnt_width(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

  function automatic int ptr_width(input int vc_w);
    return (vc_w > 1) ? $clog2(vc_w) : 1;
  endfunction
endpackage

// File: rtl/noc_vc_tx_arbiter_if.sv
// Credit-based NoC link: per-VC target select, one packet bus, per-VC credit return.
interface noc_if
  import noc_vc_tx_arbiter_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W,
  parameter int A_W  = DEFAULT_A_W,
  parameter int D_W  = DEFAULT_D_W
);
  localparam int PKT_W = 1 + A_W + D_W;

  logic [VC_W-1:0]  vc_target;
  logic [PKT_W-1:0] packet;
  logic [VC_W-1:0]  vc_credit_gnt;

  modport transmitter (output vc_target, output packet, input  vc_credit_gnt);
  modport receiver    (input  vc_target, input  packet, output vc_credit_gnt);
  modport master      (output vc_target, output packet, input  vc_credit_gnt);
  modport slave       (input  vc_target, input  packet, output vc_credit_gnt);
endinterface

// File: rtl/noc_vc_tx_arbiter_chk.sv
// Protocol checker for noc_vc_tx_arbiter; flags credit grants that arrive at MAX_CREDITS.
module noc_vc_tx_arbiter_chk #(
  parameter int VC_W        = 2,
  parameter int MAX_CREDITS = 4,
  parameter int CNT_W       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VC_W-1:0]            in_valid,
  input  logic [VC_W-1:0]            in_ready,
  input  logic [VC_W-1:0][CNT_W-1:0] credit_cnt,
  input  logic [VC_W-1:0]            vc_target,
  input  logic [VC_W-1:0]            vc_credit_gnt,
  output logic                       o_gnt_at_max_seen
);
  logic [VC_W-1:0] w_zero;
  logic [VC_W-1:0] w_at_max;

  always_comb begin
    w_zero   = '0;
    w_at_max = '0;
    for (int v = 0; v < VC_W; v++) begin
      w_zero[v]   = (credit_cnt[v] == '0);
      w_at_max[v] = (credit_cnt[v] == CNT_W'(MAX_CREDITS));
    end
  end

  // Sticky record of an over-return so a bench can observe it.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_gnt_at_max_seen <= 1'b0;
    end else if (|(vc_credit_gnt & w_at_max)) begin
      o_gnt_at_max_seen <= 1'b1;
    end else begin
      o_gnt_at_max_seen <= o_gnt_at_max_seen;
    end
  end

  a_ready_onehot0:  assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_target_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(vc_target));
  a_no_acc_at_zero: assert property (@(posedge clk) disable iff (rst) !(|(in_valid & in_ready & w_zero)));
  a_gnt_at_max:     assert property (@(posedge clk) disable iff (rst) !(|(vc_credit_gnt & w_at_max)))
    else $warning("credit grant on a VC already at MAX_CREDITS");
endmodule

// File: rtl/noc_vc_tx_arbiter_credit_ctr.sv
// Single-VC up/down credit counter, saturating at both MAX_CREDITS and zero.
module noc_credit_ctr #(
  parameter int MAX_CREDITS = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dec,
  input  logic             i_inc,
  output logic             o_nonzero,
  output logic [CNT_W-1:0] o_count
);
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CREDITS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Simultaneous inc and dec cancel; a grant at MAX is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= MAX_VAL;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   r_count <= (r_count != MAX_VAL) ? r_count + ONE : r_count;
        2'b01:   r_count <= (r_count != '0) ? r_count - ONE : r_count;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_nonzero = (r_count != '0);
  assign o_count   = r_count;
endmodule

// File: rtl/noc_vc_tx_arbiter.sv
// Round-robin, credit-gated VC scheduler driving one noc_if link with a registered output.
// Optional wormhole packet lock: define NOC_TX_ARB_PKT_LOCK_EN.
module noc_vc_tx_arbiter
  import noc_vc_tx_arbiter_pkg::*;
#(
  parameter  int VC_W        = DEFAULT_VC_W,
  parameter  int A_W         = DEFAULT_A_W,
  parameter  int D_W         = DEFAULT_D_W,
  parameter  int MAX_CREDITS = DEFAULT_MAX_CREDITS,
  localparam int CNT_W       = cnt_width(MAX_CREDITS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VC_W-1:0]            in_valid,
  output logic [VC_W-1:0]            in_ready,
  input  logic [VC_W-1:0][A_W-1:0]   in_addr,
  input  logic [VC_W-1:0][D_W-1:0]   in_data,
  input  logic [VC_W-1:0]            in_last,
  output logic [VC_W-1:0][CNT_W-1:0] credit_cnt,
  noc_if.transmitter                 to_tx
);
  localparam int PTR_W = ptr_width(VC_W);
  localparam int PKT_W = 1 + A_W + D_W;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;
  logic             w_any;
  logic [VC_W-1:0]  w_nonzero;
  logic [VC_W-1:0]  w_elig;
  logic [VC_W-1:0]  w_cand;
  logic [VC_W-1:0]  w_onehot;
  logic [VC_W-1:0]  r_vc_target;
  logic [PKT_W-1:0] r_packet;

  for (genvar v = 0; v < VC_W; v++) begin : g_ctr
    noc_credit_ctr #(.MAX_CREDITS(MAX_CREDITS), .CNT_W(CNT_W)) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .i_dec     (w_any && (w_win == PTR_W'(v))),
      .i_inc     (to_tx.vc_credit_gnt[v]),
      .o_nonzero (w_nonzero[v]),
      .o_count   (credit_cnt[v])
    );
  end

  assign w_elig = in_valid & w_nonzero;

`ifdef NOC_TX_ARB_PKT_LOCK_EN
  logic             r_lock;
  logic [PTR_W-1:0] r_lock_vc;

  assign w_cand = r_lock ? (w_elig & (VC_W'(1) << r_lock_vc)) : w_elig;

  // Hold the link for one VC from a non-last flit until its last flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock    <= 1'b0;
      r_lock_vc <= '0;
    end else if (w_any) begin
      r_lock    <= !in_last[w_win];
      r_lock_vc <= w_win;
    end else begin
      r_lock    <= r_lock;
      r_lock_vc <= r_lock_vc;
    end
  end
`else
  assign w_cand = w_elig;
`endif

  // Scan from the farthest slot back to r_ptr so the nearest candidate wins.
  always_comb begin
    w_any = |w_cand;
    w_win = '0;
    for (int k = VC_W - 1; k >= 0; k--) begin
      w_win = w_cand[(int'(r_ptr) + k) % VC_W] ? PTR_W'((int'(r_ptr) + k) % VC_W) : w_win;
    end
  end

  assign w_onehot = w_any ? (VC_W'(1) << w_win) : '0;
  assign in_ready = w_onehot;

  // Registered link select and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vc_target <= '0;
      r_ptr       <= '0;
    end else begin
      r_vc_target <= w_onehot;
      if (w_any) begin
        r_ptr <= (w_win == PTR_W'(VC_W - 1)) ? '0 : w_win + PTR_W'(1);
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  // Payload is qualified by vc_target, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_any) begin
      r_packet <= {in_last[w_win], in_addr[w_win], in_data[w_win]};
    end else begin
      r_packet <= r_packet;
    end
  end

  assign to_tx.vc_target = r_vc_target;
  assign to_tx.packet    = r_packet;
endmodule

// File: tb/tb_noc_vc_tx_arbiter.sv
// Bench for noc_vc_tx_arbiter: directed table, hand sequences and a random run against a model.
module tb_noc_vc_tx_arbiter;
  import noc_vc_tx_arbiter_pkg::*;

  localparam int VC_W  = 2;
  localparam int A_W   = 8;
  localparam int D_W   = 16;
  localparam int MAXC  = 4;
  localparam int CNT_W = cnt_width(MAXC);
  localparam int PKT_W = 1 + A_W + D_W;
`ifdef NOC_TX_ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [VC_W-1:0]            in_valid, in_ready, in_last, gnt;
  logic [VC_W-1:0][A_W-1:0]   in_addr;
  logic [VC_W-1:0][D_W-1:0]   in_data;
  logic [VC_W-1:0][CNT_W-1:0] credit_cnt;
  logic                       gnt_at_max_seen;

  always #5 clk = ~clk;

  noc_if #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W)) link ();
  assign link.vc_credit_gnt = gnt;

  noc_vc_tx_arbiter #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .MAX_CREDITS(MAXC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_last(in_last), .credit_cnt(credit_cnt), .to_tx(link.transmitter)
  );

  noc_vc_tx_arbiter_chk #(.VC_W(VC_W), .MAX_CREDITS(MAXC), .CNT_W(CNT_W)) u_chk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .credit_cnt(credit_cnt),
    .vc_target(link.vc_target), .vc_credit_gnt(gnt), .o_gnt_at_max_seen(gnt_at_max_seen)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: credits per VC, RR pointer, last accepted output, wormhole lock
  int               m_cred[VC_W];
  int               m_ptr;
  logic [VC_W-1:0]  m_target;
  logic [PKT_W-1:0] m_pkt;
  bit               m_lock;
  int               m_lock_vc;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < VC_W; v++) m_cred[v] = MAXC;
    m_ptr = 0; m_target = '0; m_pkt = '0; m_lock = 1'b0; m_lock_vc = 0;
  endtask

  function automatic int m_winner();
    for (int k = 0; k < VC_W; k++) begin
      int v = (m_ptr + k) % VC_W;
      if (in_valid[v] && m_cred[v] > 0 && (!m_lock || v == m_lock_vc)) return v;
    end
    return -1;
  endfunction

  task automatic apply(input logic [VC_W-1:0] v, input logic [VC_W-1:0] l, input logic [VC_W-1:0] g);
    @(negedge clk);
    in_valid = v; in_last = l; gnt = g;
    for (int i = 0; i < VC_W; i++) begin
      in_addr[i] = A_W'($urandom);
      in_data[i] = D_W'($urandom);
    end
    #1;
  endtask

  // Compare DUT against the model for this cycle, then advance the model across the edge.
  task automatic model_step();
    int w;
    logic [VC_W-1:0] one, exp_rdy;
    one = 1;
    w = m_winner();
    exp_rdy = (w >= 0) ? (one << w) : '0;
    chk_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk_eq("vc_target", 32'(link.vc_target), 32'(m_target));
    if (m_target != '0) chk_eq("packet", 32'(link.packet), 32'(m_pkt));
    for (int v = 0; v < VC_W; v++) chk_eq("credit_cnt", 32'(credit_cnt[v]), 32'(m_cred[v]));
    for (int v = 0; v < VC_W; v++) begin
      int c = m_cred[v];
      if (w == v) c--;
      if (gnt[v]) c++;
      m_cred[v] = (c > MAXC) ? MAXC : c;
    end
    if (w >= 0) begin
      m_target  = one << w;
      m_pkt     = {in_last[w], in_addr[w], in_data[w]};
      m_ptr     = (w + 1) % VC_W;
      m_lock    = LOCK_EN && !in_last[w];
      m_lock_vc = w;
    end else begin
      m_target = '0;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = '0; in_last = '0; gnt = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [VC_W-1:0] v;
    logic [VC_W-1:0] g;
    logic [VC_W-1:0] rdy;
    int              c0;
    int              c1;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [VC_W-1:0] h0, h1, h2, g, exp, sent_rdy;
    int f;
    rst = 1'b1; in_valid = '0; in_last = '0; gnt = '0; in_addr = '0; in_data = '0;

    // Drain VC0, credit edge cases on VC0/VC1, over-return at MAX on VC1
    tbl[0]  = '{2'b00, 2'b00, 2'b00, 4, 4};
    tbl[1]  = '{2'b01, 2'b00, 2'b01, 4, 4};
    tbl[2]  = '{2'b01, 2'b00, 2'b01, 3, 4};
    tbl[3]  = '{2'b01, 2'b00, 2'b01, 2, 4};
    tbl[4]  = '{2'b01, 2'b00, 2'b01, 1, 4};
    tbl[5]  = '{2'b01, 2'b00, 2'b00, 0, 4};
    tbl[6]  = '{2'b01, 2'b01, 2'b00, 0, 4};
    tbl[7]  = '{2'b01, 2'b00, 2'b01, 1, 4};
    tbl[8]  = '{2'b00, 2'b00, 2'b00, 0, 4};
    tbl[9]  = '{2'b10, 2'b00, 2'b10, 0, 4};
    tbl[10] = '{2'b10, 2'b00, 2'b10, 0, 3};
    tbl[11] = '{2'b10, 2'b10, 2'b10, 0, 2};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 0, 2};
    tbl[13] = '{2'b00, 2'b01, 2'b00, 0, 2};
    tbl[14] = '{2'b00, 2'b10, 2'b00, 1, 2};
    tbl[15] = '{2'b00, 2'b10, 2'b00, 1, 3};
    tbl[16] = '{2'b00, 2'b00, 2'b00, 1, 4};
    tbl[17] = '{2'b00, 2'b10, 2'b00, 1, 4};
    tbl[18] = '{2'b00, 2'b00, 2'b00, 1, 4};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].v, 2'b11, tbl[i].g);
      chk_eq("tbl_ready", 32'(in_ready), 32'(tbl[i].rdy));
      chk_eq("tbl_cnt0", 32'(credit_cnt[0]), 32'(tbl[i].c0));
      chk_eq("tbl_cnt1", 32'(credit_cnt[1]), 32'(tbl[i].c1));
      if (i == 0) chk_eq("reset_target", 32'(link.vc_target), 32'd0);
      if (i == 17) chk_eq("ovf_flag_clear", 32'(gnt_at_max_seen), 32'd0);
      model_step();
    end
    chk_eq("ovf_flag_set", 32'(gnt_at_max_seen), 32'd1);

    // VC0 starved of credit: VC1 served every cycle until VC0's credit returns
    apply(2'b01, 2'b11, 2'b00);
    model_step();
    h0 = '0;
    for (int i = 0; i < 6; i++) begin
      apply(2'b11, 2'b11, h0);
      chk_eq("starve_ready", 32'(in_ready), 32'(2'b10));
      h0 = in_ready & 2'b10;
      model_step();
    end
    apply(2'b11, 2'b11, h0 | 2'b01);
    chk_eq("gnt_same_cycle_ready", 32'(in_ready), 32'(2'b10));
    h0 = in_ready & 2'b10;
    model_step();
    apply(2'b11, 2'b11, h0);
    chk_eq("vc0_resumes", 32'(in_ready), 32'(2'b01));
    model_step();

    // Both VCs saturated, credits returned three cycles after each accept
    do_reset();
    h0 = '0; h1 = '0; h2 = '0;
    for (int i = 0; i < 12; i++) begin
      apply(2'b11, 2'b11, h2);
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk_eq("alt_ready", 32'(in_ready), 32'(exp));
      h2 = h1; h1 = h0; h0 = in_ready & in_valid;
      model_step();
    end

    // Three-flit packet on VC0 competing with VC1
    do_reset();
    f = 0;
    for (int i = 0; i < 4; i++) begin
      apply({1'b1, f < 3}, {1'b1, f == 2}, 2'b00);
      if (LOCK_EN) exp = (i < 3) ? 2'b01 : 2'b10;
      else         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk_eq("pkt_order", 32'(in_ready), 32'(exp));
      sent_rdy = in_ready;
      if (sent_rdy[0]) f++;
      model_step();
    end

    // Random traffic with legal credit returns
    do_reset();
    for (int i = 0; i < 300; i++) begin
      g = '0;
      for (int v = 0; v < VC_W; v++) g[v] = (m_cred[v] < MAXC) && ($urandom_range(0, 2) == 0);
      apply(VC_W'($urandom), VC_W'($urandom), g);
      model_step();
    end

    // Reset mid-traffic drops the in-flight flit and restores credits
    apply(2'b11, 2'b01, 2'b00);
    model_step();
    do_reset();
    apply(2'b00, 2'b00, 2'b00);
    chk_eq("midreset_target", 32'(link.vc_target), 32'd0);
    chk_eq("midreset_cnt0", 32'(credit_cnt[0]), 32'(MAXC));
    model_step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
